// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared encodings and constants for the instruction fetch stage
//
// Purpose : jump/jr control encodings from the decoder, the bubble (NOP)
//           word, the reset PC, and the j/jal target helper.
// Ports   : none (package).

package if_stage_pkg;

    typedef enum logic [1:0] {
        JJR_NONE = 2'b00,
        JJR_JR   = 2'b01,
        JJR_J    = 2'b10
    } jjr_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Pseudo-direct j/jal target: region bits of the link PC, word index from
    // the instruction, word-aligned.
    function automatic logic [31:0] j_target(input logic [3:0]  region,
                                             input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// rtl/if_next_pc.sv - combinational next-PC selection for the fetch stage
//
// Purpose : picks the next fetch address: flush target, held PC, j/jal
//           target, jr register value, or sequential PC+4 (highest first).
// Ports   : pc_i            current PC
//           seq_pc_i        current PC + 4 (modulo 2^32)
//           flush_i         branch redirect, overrides everything
//           branch_target_i branch redirect address
//           stall_i         hold the PC
//           ifid_valid_i    IF/ID holds a real instruction
//           jjr_i           decoder jump class (NONE/JR/J)
//           jump_region_i   IF/ID PC+4 bits [31:28]
//           jump_index_i    IF/ID instruction bits [25:0]
//           jr_addr_i       rs value for jr
//           next_pc_o       selected next PC
//           jump_taken_o    a j/jal or jr redirect is being taken

import if_stage_pkg::*;

module if_next_pc (
    input  logic [31:0] pc_i,
    input  logic [31:0] seq_pc_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    input  logic        ifid_valid_i,
    input  logic [1:0]  jjr_i,
    input  logic [3:0]  jump_region_i,
    input  logic [25:0] jump_index_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] next_pc_o,
    output logic        jump_taken_o
);

    always_comb begin
        next_pc_o    = seq_pc_i;
        jump_taken_o = 1'b0;
        if (flush_i) begin
            next_pc_o = branch_target_i;
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end else if (ifid_valid_i && (jjr_i == JJR_J)) begin
            // A bubble in IF/ID carries no jump, so jjr is only trusted when valid.
            next_pc_o    = j_target(jump_region_i, jump_index_i);
            jump_taken_o = 1'b1;
        end else if (ifid_valid_i && (jjr_i == JJR_JR)) begin
            next_pc_o    = jr_addr_i;
            jump_taken_o = 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, IF/ID register, perf counters
//
// Purpose : fetches from a combinational instruction memory, registers the
//           instruction and its PC+4 into IF/ID, and redirects on flush/jump
//           by inserting a single bubble.
// Config  : IF_PERF_CNT_EN defined -> saturating fetch/stall/flush counters;
//           undefined -> counter outputs tied to 0, no counter flops.
// Ports   : clk_i, rst_i (async active-low)
//           imem_addr_o / imem_data_i   fetch address and returned word
//           stall_i, flush_i, branch_target_i, jjr_i, jr_addr_i  control
//           instr_o, pc_plus4_o, valid_o                          IF/ID
//           cnt_fetch_o, cnt_stall_o, cnt_flush_o                 counters

import if_stage_pkg::*;

module if_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    input  logic [1:0]  jjr_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic [31:0] cnt_fetch_o,
    output logic [31:0] cnt_stall_o,
    output logic [31:0] cnt_flush_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] seq_pc;
    logic        jump_taken;
    logic        bubble;
    logic        load;

    assign seq_pc = pc_q + 32'd4;

    if_next_pc u_next_pc (
        .pc_i            (pc_q),
        .seq_pc_i        (seq_pc),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .stall_i         (stall_i),
        .ifid_valid_i    (valid_q),
        .jjr_i           (jjr_i),
        .jump_region_i   (pc4_q[31:28]),
        .jump_index_i    (instr_q[25:0]),
        .jr_addr_i       (jr_addr_i),
        .next_pc_o       (pc_d),
        .jump_taken_o    (jump_taken)
    );

    // The word fetched alongside a redirect is on the wrong path, so it is
    // replaced by a bubble; flush wins over stall.
    assign bubble = flush_i | jump_taken;
    assign load   = ~bubble & ~stall_i;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bubble) begin
            instr_d = NOP_WORD;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = imem_data_i;
            pc4_d   = seq_pc;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign instr_o     = instr_q;
    assign pc_plus4_o  = pc4_q;
    assign valid_o     = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] cnt_fetch_q, cnt_stall_q, cnt_flush_q;
    logic        stall_event;

    assign stall_event = stall_i & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_fetch_q <= 32'h0;
            cnt_stall_q <= 32'h0;
            cnt_flush_q <= 32'h0;
        end else begin
            if (load && (cnt_fetch_q != 32'hFFFF_FFFF)) begin
                cnt_fetch_q <= cnt_fetch_q + 32'd1;
            end
            if (stall_event && (cnt_stall_q != 32'hFFFF_FFFF)) begin
                cnt_stall_q <= cnt_stall_q + 32'd1;
            end
            if (bubble && (cnt_flush_q != 32'hFFFF_FFFF)) begin
                cnt_flush_q <= cnt_flush_q + 32'd1;
            end
        end
    end

    assign cnt_fetch_o = cnt_fetch_q;
    assign cnt_stall_o = cnt_stall_q;
    assign cnt_flush_o = cnt_flush_q;
`else
    assign cnt_fetch_o = 32'h0;
    assign cnt_stall_o = 32'h0;
    assign cnt_flush_o = 32'h0;
`endif

endmodule
